// File: rtl/math_pkg.sv
// Elaboration-time integer helpers.
// clog2: ceiling log2, 0 for inputs of 0 or 1.
package math_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_pkg.sv
// Clock/period arithmetic shared by timing blocks.
// nb_clk_for_time: clock cycles covering a time in ns at a given MHz.
package time_pkg;

  function automatic int unsigned nb_clk_for_time(
    input int unsigned freq_mhz,
    input int unsigned time_ns
  );
    return (freq_mhz * time_ns + 999) / 1000;
  endfunction

endpackage

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for timer_scheduler.
// Tick length, prescaler width helper, channel state enum.
package timer_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  function automatic int unsigned tick_clks(
    input int unsigned freq_mhz
  );
    return time_pkg::nb_clk_for_time(freq_mhz, 1000);
  endfunction

  // Counter width for values 0..n-1, never below 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = math_pkg::clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req, rotating on advance.
// Ports: clk, rst, req[N], advance -> grant[N], ptr (top priority index).
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic                  advance,
  output logic [N-1:0]          grant,
  output logic [cnt_w(N)-1:0]   ptr
);

  localparam int PW = cnt_w(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel us timer: prescaler, RR arm arbiter, countdown table.
// Ports: arm_valid/arm_us/arm_ready, busy, expire, tick_us; TIMER_SCHED_PERIODIC_EN adds arm_periodic.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int NB_TIMERS    = 4,
  parameter int DUR_W        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NB_TIMERS-1:0]         arm_valid,
  input  logic [NB_TIMERS*DUR_W-1:0]   arm_us,
`ifdef TIMER_SCHED_PERIODIC_EN
  input  logic [NB_TIMERS-1:0]         arm_periodic,
`endif
  output logic [NB_TIMERS-1:0]         arm_ready,
  output logic [NB_TIMERS-1:0]         busy,
  output logic [NB_TIMERS-1:0]         expire,
  output logic                         tick_us
);

  localparam int unsigned TICK_CLKS = tick_clks(CLK_FREQ_MHZ);
  localparam int PS_W = cnt_w(TICK_CLKS);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_CLKS - 1);

  // Prescaler
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_q, tick_d;

  always_comb begin
    ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
    tick_d = (ps_d == PS_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
    end
  end

  // Arbiter
  logic [NB_TIMERS-1:0]       acc;
  logic [cnt_w(NB_TIMERS)-1:0] rr_ptr_unused;

  assign acc = arm_valid & arm_ready & {NB_TIMERS{~rst}};

  rr_arbiter #(
    .N (NB_TIMERS)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arm_valid),
    .advance (|acc),
    .grant   (arm_ready),
    .ptr     (rr_ptr_unused)
  );

  // Channel table
  ch_state_e [NB_TIMERS-1:0] state_q, state_d;
  logic [DUR_W-1:0]          cnt_q [NB_TIMERS];
  logic [DUR_W-1:0]          cnt_d [NB_TIMERS];
  logic [NB_TIMERS-1:0]      exp_q, exp_d;
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [NB_TIMERS-1:0]      per_q, per_d;
  logic [DUR_W-1:0]          rld_q [NB_TIMERS];
  logic [DUR_W-1:0]          rld_d [NB_TIMERS];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= {NB_TIMERS{IDLE}};
      exp_q   <= '0;
      for (int i = 0; i < NB_TIMERS; i++) cnt_q[i] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
      per_q <= '0;
      for (int i = 0; i < NB_TIMERS; i++) rld_q[i] <= '0;
`endif
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      for (int i = 0; i < NB_TIMERS; i++) cnt_q[i] <= cnt_d[i];
`ifdef TIMER_SCHED_PERIODIC_EN
      per_q <= per_d;
      for (int i = 0; i < NB_TIMERS; i++) rld_q[i] <= rld_d[i];
`endif
    end
  end

  // A same-cycle accept overrides the tick update, but an expiry
  // already earned by cnt == 1 is kept.
  always_comb begin
    state_d = state_q;
    exp_d   = '0;
    for (int i = 0; i < NB_TIMERS; i++) cnt_d[i] = cnt_q[i];
`ifdef TIMER_SCHED_PERIODIC_EN
    per_d = per_q;
    for (int i = 0; i < NB_TIMERS; i++) rld_d[i] = rld_q[i];
`endif
    for (int i = 0; i < NB_TIMERS; i++) begin
      if (state_q[i] == RUN && tick_q) begin
        if (cnt_q[i] == DUR_W'(1)) begin
          exp_d[i] = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
          if (per_q[i] && rld_q[i] != '0) begin
            cnt_d[i] = rld_q[i];
          end else begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
`else
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] - DUR_W'(1);
        end
      end
      if (acc[i]) begin
        if (arm_us[i*DUR_W +: DUR_W] == '0) begin
          exp_d[i]   = 1'b1;
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end else begin
          state_d[i] = RUN;
          cnt_d[i]   = arm_us[i*DUR_W +: DUR_W];
        end
`ifdef TIMER_SCHED_PERIODIC_EN
        per_d[i] = arm_periodic[i];
        rld_d[i] = arm_us[i*DUR_W +: DUR_W];
`endif
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NB_TIMERS; i++) begin
      busy[i] = (state_q[i] == RUN);
    end
  end

  assign expire  = exp_q;
  assign tick_us = tick_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboarded bench for timer_scheduler at 100 MHz, 4 channels.
// Stimulus pushes expected expiries; a negedge monitor checks them.
module tb_timer_scheduler;

  localparam int NB = 4;
  localparam int DW = 16;
  localparam int TK = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NB-1:0]     arm_valid = '0;
  logic [NB*DW-1:0]  arm_us = '0;
  logic [NB-1:0]     arm_per = '0;
  logic [NB-1:0]     arm_ready;
  logic [NB-1:0]     busy;
  logic [NB-1:0]     expire;
  logic              tick_us;

  timer_scheduler #(
    .CLK_FREQ_MHZ (100),
    .NB_TIMERS    (NB),
    .DUR_W        (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm_valid    (arm_valid),
    .arm_us       (arm_us),
`ifdef TIMER_SCHED_PERIODIC_EN
    .arm_periodic (arm_per),
`endif
    .arm_ready    (arm_ready),
    .busy         (busy),
    .expire       (expire),
    .tick_us      (tick_us)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int ch;
    int cy;
  } ev_t;

  ev_t sbq[$];
  int  applied = 0;
  int  miscompares = 0;
  int  rel = 0;
  bit  tick_chk = 1'b0;
  int  last_acc = 0;
  int  last_exp [NB];

  function automatic bit tick_at(input int c);
    return (c >= rel) && (((c - rel) % TK) == TK - 1);
  endfunction

  // Expire is seen the cycle after the d-th tick strictly after accept.
  function automatic int exp_cycle(input int a, input int d);
    int n;
    n = 0;
    if (d == 0) return a + 1;
    for (int c = a + 1; c < a + 1 + TK * (d + 2); c++) begin
      if (tick_at(c)) begin
        n = n + 1;
        if (n == d) return c + 1;
      end
    end
    return -1;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    applied = applied + 1;
    if (act !== req) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d required %0d (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  task automatic sb_accept(input int ch, input int a, input int d);
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].ch == ch && sbq[i].cy > a + 1) sbq.delete(i);
    end
    last_exp[ch] = exp_cycle(a, d);
    sbq.push_back('{ch: ch, cy: last_exp[ch]});
  endtask

  always @(negedge clk) begin
    bit t;
    bit want;
    t = tick_at(cyc);
    if (tick_chk && (tick_us || t)) begin
      check("tick_us", int'(tick_us), int'(t));
    end
    for (int ch = 0; ch < NB; ch++) begin
      want = 1'b0;
      foreach (sbq[i]) begin
        if (sbq[i].cy == cyc && sbq[i].ch == ch) want = 1'b1;
      end
      if (expire[ch] || want) begin
        check($sformatf("expire[%0d]", ch), int'(expire[ch]), int'(want));
      end
    end
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cy <= cyc) sbq.delete(i);
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic step(
    input logic [NB-1:0] v,
    input logic [NB-1:0] g,
    input string nm
  );
    @(posedge clk);
    #1;
    arm_valid = v;
    @(negedge clk);
    check(nm, int'(arm_ready), int'(g));
    for (int ch = 0; ch < NB; ch++) begin
      if (g[ch]) begin
        last_acc = cyc;
        sb_accept(ch, cyc, int'(arm_us[ch*DW +: DW]));
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    arm_valid = '0;
  endtask

  task automatic arm1(input int ch, input int d, input string nm);
    arm_us[ch*DW +: DW] = DW'(d);
    step(NB'(1) << ch, NB'(1) << ch, nm);
    idle();
    @(negedge clk);
    check({nm, "_busy"}, int'(busy[ch]), int'(d != 0));
  endtask

  task automatic do_reset_mid();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick_chk = 1'b0;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cy > cyc) sbq.delete(i);
    end
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_tick", int'(tick_us), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel = cyc;
    tick_chk = 1'b1;
  endtask

  initial begin
    int t;
    int e;
`ifdef TIMER_SCHED_PERIODIC_EN
    int e1;
`endif
    arm_valid = 4'b0100;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(arm_ready), 4);
    check("rst_busy", int'(busy), 0);
    check("rst_expire", int'(expire), 0);
    check("rst_tick", int'(tick_us), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    arm_valid = '0;
    rel = cyc;
    tick_chk = 1'b1;
    @(negedge clk);
    check("rst_accept_ignored", int'(busy), 0);

    wait_cyc(rel + 250);

    arm_us = {16'd5, 16'd4, 16'd3, 16'd2};
    step(4'b1111, 4'b0001, "rr_g0");
    step(4'b1110, 4'b0010, "rr_g1");
    step(4'b1100, 4'b0100, "rr_g2");
    step(4'b1000, 4'b1000, "rr_g3");
    step(4'b0001, 4'b0001, "rr_ch0");
    step(4'b0011, 4'b0010, "rr_ch1_next");
    step(4'b0001, 4'b0001, "rr_ch0_after");
    idle();
    wait_cyc(cyc + 800);

    t = cyc + 1;
    while (!tick_at(t)) t = t + 1;
    wait_cyc(t + 9);
    arm1(2, 5, "oneshot");
    wait_cyc(last_exp[2]);
    check("oneshot_busy_low", int'(busy[2]), 0);

    arm1(3, 0, "zero");
    wait_cyc(cyc + 5);

    arm1(1, 3, "rearm_a");
    wait_cyc(last_acc + 199);
    arm1(1, 10, "rearm_b");
    wait_cyc(last_exp[1] + 5);

    arm1(0, 4, "simul_a");
    e = last_exp[0];
    wait_cyc(e - 2);
    arm1(0, 4, "simul_b");
    @(negedge clk);
    check("simul_busy_hold", int'(busy[0]), 1);
    wait_cyc(last_exp[0] + 5);

    arm1(2, 5, "midrst_arm");
    wait_cyc(last_acc + 150);
    do_reset_mid();
    arm_us[0 +: DW] = 16'd1;
    step(4'b1001, 4'b0001, "rst_ptr");
    idle();
    wait_cyc(cyc + 700);

`ifdef TIMER_SCHED_PERIODIC_EN
    arm_per[1] = 1'b1;
    arm1(1, 3, "per");
    e1 = last_exp[1];
    sbq.push_back('{ch: 1, cy: e1 + 300});
    sbq.push_back('{ch: 1, cy: e1 + 600});
    wait_cyc(e1 + 650);
    check("per_busy", int'(busy[1]), 1);
    arm_per[1] = 1'b0;
    arm1(1, 0, "per_stop");
    wait_cyc(cyc + 400);
`endif

    wait_cyc(cyc + 20);
    check("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
